// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side inputs, MEM/WB forwarding sources and EX-side outputs
// around the ID/EX pipeline register.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [RA_W-1:0] id_rd_addr;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [3:0]      id_alu_ctrl;
  logic            id_use_imm;
  logic            id_use_pc;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_is_branch;

  logic [RA_W-1:0] mem_rd_addr;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RA_W-1:0] wb_rd_addr;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;

  logic            flush;
  logic            ex_stall;

  logic [XLEN-1:0] alu_data0;
  logic [XLEN-1:0] alu_data1;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_is_branch;
  logic            id_hold;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_used, id_rs2_used,
           id_alu_ctrl, id_use_imm, id_use_pc, id_reg_write, id_mem_read,
           id_mem_write, id_is_branch,
           mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_result, flush, ex_stall,
    input  alu_data0, alu_data1, alu_ctrl, ex_store_data, ex_pc, ex_rd_addr,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch,
           id_hold
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_used, id_rs2_used,
           id_alu_ctrl, id_use_imm, id_use_pc, id_reg_write, id_mem_read,
           id_mem_write, id_is_branch,
           mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_result, flush, ex_stall,
    output alu_data0, alu_data1, alu_ctrl, ex_store_data, ex_pc, ex_rd_addr,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch,
           id_hold
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion, branch flush and downstream stall hold.
module id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [RA_W-1:0] mem_rd_addr_i,
  input  logic            mem_reg_write_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [RA_W-1:0] wb_rd_addr_i,
  input  logic            wb_reg_write_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic [XLEN-1:0] fwd_o
);
  logic mem_hit, wb_hit;

  // x0 is hardwired zero, so a write to it must never be forwarded
  assign mem_hit = mem_reg_write_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == rs_addr_i);
  assign wb_hit  = wb_reg_write_i  && (wb_rd_addr_i  != '0) && (wb_rd_addr_i  == rs_addr_i);
  assign fwd_o   = mem_hit ? mem_result_i : (wb_hit ? wb_result_i : rf_data_i);
endmodule

module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic [3:0]      alu_ctrl;
    logic            use_imm;
    logic            use_pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    load_use;

  logic [NUM_SRC-1:0][RA_W-1:0] src_addr;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_data;

  // Only a load sitting in EX can create a hazard; a flush kills the ID instruction anyway
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && bus.id_valid &&
                    ((bus.id_rs1_used && (bus.id_rs1_addr == ex_q.rd_addr)) ||
                     (bus.id_rs2_used && (bus.id_rs2_addr == ex_q.rd_addr))) &&
                    !bus.flush;
  assign bus.id_hold = bus.ex_stall || load_use;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.ex_stall) begin
      ex_d = ex_q;
    end else if (load_use || !bus.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.mem_write = bus.id_mem_write;
      ex_d.is_branch = bus.id_is_branch;
      ex_d.alu_ctrl  = bus.id_alu_ctrl;
      ex_d.use_imm   = bus.id_use_imm;
      ex_d.use_pc    = bus.id_use_pc;
      ex_d.rs1_addr  = bus.id_rs1_addr;
      ex_d.rs2_addr  = bus.id_rs2_addr;
      ex_d.rd_addr   = bus.id_rd_addr;
      ex_d.pc        = bus.id_pc;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign src_addr[0] = ex_q.rs1_addr;
  assign src_addr[1] = ex_q.rs2_addr;
  assign src_data[0] = ex_q.rs1_data;
  assign src_data[1] = ex_q.rs2_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs_addr_i      (src_addr[g]),
      .rf_data_i      (src_data[g]),
      .mem_rd_addr_i  (bus.mem_rd_addr),
      .mem_reg_write_i(bus.mem_reg_write),
      .mem_result_i   (bus.mem_result),
      .wb_rd_addr_i   (bus.wb_rd_addr),
      .wb_reg_write_i (bus.wb_reg_write),
      .wb_result_i    (bus.wb_result),
      .fwd_o          (fwd_data[g])
    );
  end

  assign bus.alu_data0     = ex_q.use_pc  ? ex_q.pc  : fwd_data[0];
  assign bus.alu_data1     = ex_q.use_imm ? ex_q.imm : fwd_data[1];
  assign bus.ex_store_data = fwd_data[1];
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_is_branch  = ex_q.is_branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding priority,
// load-use bubble, flush, stall hold and operand select.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_alu_ctrl = 0;
    bus.id_use_imm = 0; bus.id_use_pc = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_is_branch = 0;
    bus.mem_rd_addr = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    bus.wb_rd_addr = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
    bus.flush = 0; bus.ex_stall = 0;
  endtask

  // Plain register-register instruction in ID
  task automatic rr(input logic [4:0] rs1, input logic [31:0] d1,
                    input logic [4:0] rs2, input logic [31:0] d2,
                    input logic [4:0] rd, input logic [3:0] op);
    bus.id_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2; bus.id_rs2_data = d2; bus.id_rd_addr = rd;
    bus.id_rs1_used = 1; bus.id_rs2_used = 1; bus.id_alu_ctrl = op;
    bus.id_reg_write = 1; bus.id_use_imm = 0; bus.id_use_pc = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_is_branch = 0;
  endtask

  initial begin
    clr();
    // reset with garbage in ID
    rst_n = 0;
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_alu_ctrl = 4'(($urandom % 15) + 1);
    bus.id_pc = $urandom | 32'h1; bus.id_rs1_data = $urandom; bus.id_rd_addr = 5'd7;
    tick(); tick();
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 0);
    chk("rst_reg_write", 32'(bus.ex_reg_write), 0);
    chk("rst_pc", bus.ex_pc, 0);

    // ADD x9 = x3 + x4 right after reset release
    clr();
    rst_n = 1;
    rr(5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 4'b0000);
    tick();
    chk("add_d0", bus.alu_data0, 32'd5);
    chk("add_d1", bus.alu_data1, 32'd7);
    chk("add_ctrl", 32'(bus.alu_ctrl), 0);
    chk("add_valid", 32'(bus.ex_valid), 1);
    chk("add_rd", 32'(bus.ex_rd_addr), 9);

    // forwarding priority on rs1=6, rs2=x0
    rr(5'd6, 32'h66, 5'd0, 32'h77, 5'd10, 4'b0001);
    tick();
    bus.id_valid = 0;
    bus.mem_rd_addr = 6; bus.mem_reg_write = 1; bus.mem_result = 32'h11;
    bus.wb_rd_addr = 6; bus.wb_reg_write = 1; bus.wb_result = 32'h22;
    #1 chk("fwd_mem", bus.alu_data0, 32'h11);
    bus.mem_reg_write = 0;
    #1 chk("fwd_wb", bus.alu_data0, 32'h22);
    bus.mem_reg_write = 1; bus.mem_rd_addr = 0; bus.wb_rd_addr = 0;
    #1 chk("fwd_rf", bus.alu_data0, 32'h66);
    chk("fwd_x0", bus.ex_store_data, 32'h77);
    // invalid ID on capture yields a bubble
    bus.id_reg_write = 1;
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 0);
    chk("inv_reg_write", 32'(bus.ex_reg_write), 0);

    // load-use: LW x8 then ADD reading x8 through rs2
    clr();
    rr(5'd1, 32'h100, 5'd0, 0, 5'd8, 4'b0000);
    bus.id_mem_read = 1; bus.id_rs2_used = 0;
    tick();
    rr(5'd2, 32'h2, 5'd8, 32'h8, 5'd11, 4'b0000);
    #1 chk("lu_hold", 32'(bus.id_hold), 1);
    tick();
    chk("lu_bubble", 32'(bus.ex_valid), 0);
    chk("lu_bubble_mr", 32'(bus.ex_mem_read), 0);
    chk("lu_release", 32'(bus.id_hold), 0);
    tick();
    chk("lu_cap_valid", 32'(bus.ex_valid), 1);
    chk("lu_cap_rd", 32'(bus.ex_rd_addr), 11);

    // flush with a valid SUB in ID
    rr(5'd1, 1, 5'd2, 2, 5'd12, 4'b0001);
    bus.flush = 1;
    tick();
    chk("fl_valid", 32'(bus.ex_valid), 0);
    chk("fl_reg_write", 32'(bus.ex_reg_write), 0);
    // flush masks a pending load-use
    bus.flush = 0;
    rr(5'd1, 0, 5'd0, 0, 5'd8, 4'b0000);
    bus.id_mem_read = 1;
    tick();
    rr(5'd8, 0, 5'd3, 0, 5'd13, 4'b0000);
    #1 chk("fl_lu_pre", 32'(bus.id_hold), 1);
    bus.flush = 1;
    #1 chk("fl_lu_hold", 32'(bus.id_hold), 0);
    tick();
    chk("fl_lu_valid", 32'(bus.ex_valid), 0);

    // stall hold across changing ID fields
    clr();
    rr(5'd1, 0, 5'd2, 0, 5'd12, 4'b0011);
    bus.id_pc = 32'h200;
    tick();
    bus.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      rr(5'(i + 4), 32'(i), 5'(i + 5), 32'(i), 5'(i + 20), 4'(i + 7));
      bus.id_pc = 32'h400 + 32'(i);
      #1 chk("st_hold", 32'(bus.id_hold), 1);
      tick();
      chk("st_pc", bus.ex_pc, 32'h200);
      chk("st_rd", 32'(bus.ex_rd_addr), 12);
      chk("st_ctrl", 32'(bus.alu_ctrl), 3);
      chk("st_valid", 32'(bus.ex_valid), 1);
    end
    bus.flush = 1;
    tick();
    chk("st_flush_valid", 32'(bus.ex_valid), 0);
    chk("st_flush_ctrl", 32'(bus.alu_ctrl), 0);

    // AUIPC operand select
    clr();
    bus.id_valid = 1; bus.id_use_pc = 1; bus.id_use_imm = 1; bus.id_reg_write = 1;
    bus.id_pc = 32'h100; bus.id_imm = 32'h1000; bus.id_rs1_data = 32'hDEAD; bus.id_rd_addr = 5'd14;
    tick();
    chk("auipc_d0", bus.alu_data0, 32'h100);
    chk("auipc_d1", bus.alu_data1, 32'h1000);
    // SW with rs2 forwarded from WB
    clr();
    bus.id_valid = 1; bus.id_use_imm = 1; bus.id_mem_write = 1; bus.id_imm = 8;
    bus.id_rs1_addr = 1; bus.id_rs1_data = 32'h40; bus.id_rs1_used = 1;
    bus.id_rs2_addr = 5; bus.id_rs2_data = 32'hAAAA; bus.id_rs2_used = 1;
    tick();
    bus.id_valid = 0;
    bus.wb_rd_addr = 5; bus.wb_reg_write = 1; bus.wb_result = 32'hBEEF;
    #1 chk("sw_store", bus.ex_store_data, 32'hBEEF);
    chk("sw_d1", bus.alu_data1, 32'h8);
    chk("sw_d0", bus.alu_data0, 32'h40);
    chk("sw_mw", 32'(bus.ex_mem_write), 1);

    // reset wins over a stall
    clr();
    rr(5'd1, 0, 5'd2, 0, 5'd15, 4'b0010);
    tick();
    bus.ex_stall = 1; rst_n = 0;
    tick();
    chk("rst_stall_valid", 32'(bus.ex_valid), 0);
    chk("rst_stall_ctrl", 32'(bus.alu_ctrl), 0);
    rst_n = 1;
    clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register between decode and execute in the 5-stage RV32IM core. It captures decoded operands and control each cycle. Using its registered source addresses, it applies MEM/WB operand forwarding and drives the execute ALU's data0, data1 and ctrl inputs. It also detects load-use hazards, inserts bubbles, and handles branch flush and downstream stall.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
id_valid  input  1  ID holds a valid instruction
id_pc  input  XLEN  PC of the ID instruction
id_rs1_data / id_rs2_data  input  XLEN  register-file read data
id_imm  input  XLEN  sign-extended immediate
id_rs1_addr / id_rs2_addr / id_rd_addr  input  RA_W  register indices
id_rs1_used / id_rs2_used  input  1  instruction actually reads rs1/rs2
id_alu_ctrl  input  4  ALU op code (0000 ADD … 1111 MULH)
id_use_imm  input  1  data1 = immediate
id_use_pc  input  1  data0 = PC (AUIPC/JAL)
id_reg_write, id_mem_read, id_mem_write, id_is_branch  input  1 each  decoded control
mem_rd_addr  input  RA_W  destination of the instruction in MEM
mem_reg_write  input  1  MEM instruction writes rd
mem_result  input  XLEN  MEM-stage ALU result
wb_rd_addr  input  RA_W  destination of the instruction in WB
wb_reg_write  input  1  WB instruction writes rd
wb_result  input  XLEN  WB writeback value
flush  input  1  taken branch/jump resolved in EX
ex_stall  input  1  downstream cannot accept; hold EX
alu_data0, alu_data1  output  XLEN  forwarded ALU operands (combinational from registers)
alu_ctrl  output  4  registered ALU op
ex_store_data  output  XLEN  forwarded rs2 for stores
ex_pc  output  XLEN  registered PC
ex_rd_addr  output  RA_W  registered rd
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  output  1 each  registered control
id_hold  output  1  IF/ID must hold this cycle (combinational)

Behaviour:
- Reset (rst_n=0 at edge): all registered outputs 0, including ex_valid=0, ex_pc=0 and alu_ctrl=4'b0000.
- Per-edge update priority: reset > flush > ex_stall > load-use bubble > capture.
  - flush: load a bubble.
  - ex_stall: hold every register unchanged.
  - bubble: ex_valid=0; reg_write, mem_read, mem_write, is_branch and alu_ctrl=0; datapath fields don't-care, driven 0.
  - capture: register all id_* fields; ex_valid=id_valid.
- If id_valid=0 on capture, control bits are forced 0 (same as a bubble).
- Load-use:
  - load_use = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
  - load_use is gated off when flush=1.
  - id_hold = ex_stall | load_use.
  - A load-use stall costs exactly one bubble; on the next cycle the load has left EX and the instruction is captured.
- Forwarding (combinational, on registered rs1/rs2 addresses):
  - Per source: if the mem match holds (mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==rsX) take mem_result.
  - Else if the same match holds for WB take wb_result.
  - Else take the registered RF data.
  - MEM has priority over WB; x0 is never forwarded.
- ALU operand select: alu_data0 = use_pc ? ex_pc : fwd_rs1; alu_data1 = use_imm ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2 always.
- Latency: 1 cycle from ID to EX outputs; forwarding adds zero cycles.
- Reset mid-stall or mid-flush: reset wins; after reset only the bubble state exists.

Test Plan:
- Reset: hold rst_n=0 two cycles with random id_* -> ex_valid=0, alu_ctrl=0, ex_reg_write=0; release and capture ADD rs1=3 (data 5), rs2=4 (data 7) -> next cycle alu_data0=5, alu_data1=7, alu_ctrl=0000.
- Forward priority: EX rs1=6; mem_rd=6/mem_result=0x11; wb_rd=6/wb_result=0x22 -> alu_data0=0x11; drop mem_reg_write -> 0x22; set both rd=0 -> RF value.
- Load-use: EX holds LW rd=8; ID has ADD rs2=8, id_rs2_used=1 -> id_hold=1 for one cycle, next EX is bubble (ex_valid=0), following cycle ADD captured.
- Flush: flush=1 with a valid SUB in ID -> next ex_valid=0, ex_reg_write=0; flush together with a load-use condition -> id_hold=0.
- Stall hold: ex_stall=1 for 3 cycles with changing id_* -> EX registers unchanged, id_hold=1; flush during ex_stall -> bubble loaded.
- Operand select: AUIPC id_use_pc=1, pc=0x100, imm=0x1000 -> alu_data0=0x100, alu_data1=0x1000; SW with rs2 forwarded from WB -> ex_store_data=wb_result.
